// File: rtl/cmm_chain_controller.sv
// cmm_chain_controller: row sequencer for the consecutive matrix multiplier (stage-1 stream, stage-2 accumulate).
// Optional watchdog enabled by defining CMM_TIMEOUT_EN.
module cmm_chain_controller #(
    parameter int K_DIM       = 64,
    parameter int K2_DIM      = 9,
    parameter int ROWS        = 32,
    parameter int NUM_PU      = 2,
    parameter int ADDR_W      = 11,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic                                    START,
    input  logic                                    ABORT,
    input  logic [ADDR_W-1:0]                       BASE_ADDR,
    input  logic                                    PU_DONE,
    output logic                                    PU_PREVENT_ADR_CLR,
    output logic                                    PU_ACC_CLR,
    output logic                                    PU_START,
    output logic [$clog2(K_DIM)-1:0]                PU_ACC_NUM,
    output logic [NUM_PU-1:0]                       PU_SEL,
    output logic [ADDR_W-1:0]                       INPUT_BRAM_ADDR,
    output logic                                    INPUT_BRAM_RD_EN,
    output logic                                    SHIFT_EN,
    output logic                                    DATA_IN_EN,
    output logic                                    BUSY,
    output logic                                    DONE,
    output logic                                    DONE_ROW,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] ROW_NUM,
    output logic                                    ERROR
);
    localparam int AW = $clog2(K_DIM);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [3:0] {
        IDLE, LOAD, STREAM, WAIT1, CAP0, CAP1, CLR, START2, STREAM2, ROW_END, GAP, FINISH
    } state_t;

    state_t        state, next;
    logic [AW-1:0] cnt;
    logic          timeout;
    logic          accept;

    assign accept = state == IDLE && START && !ABORT;

`ifdef CMM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    logic          waiting;

    assign waiting = state == WAIT1 || state == STREAM2;
    assign timeout = waiting && !PU_DONE && tcnt == TW'(TIMEOUT_CYC - 1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt  <= '0;
            ERROR <= 1'b0;
        end else begin
            tcnt <= waiting ? tcnt + 1'b1 : '0;
            if (accept)
                ERROR <= 1'b0;
            else if (timeout && !ABORT)
                ERROR <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign ERROR   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            cnt             <= '0;
            INPUT_BRAM_ADDR <= '0;
            ROW_NUM         <= '0;
        end else begin
            state <= next;
            cnt   <= (state == STREAM) ? cnt + 1'b1 : '0;
            if (accept) begin
                INPUT_BRAM_ADDR <= BASE_ADDR;
                ROW_NUM         <= '0;
            end else if (!ABORT && state == STREAM) begin
                INPUT_BRAM_ADDR <= INPUT_BRAM_ADDR + 1'b1;
            end else if (!ABORT && state == ROW_END) begin
                INPUT_BRAM_ADDR <= INPUT_BRAM_ADDR + 1'b1;
                ROW_NUM         <= ROW_NUM + 1'b1;
            end
        end
    end

    // ABORT outranks every other transition once a run is in progress
    always_comb begin
        next = state;
        if (state != IDLE && ABORT)
            next = IDLE;
        else
            case (state)
                IDLE:    next = accept ? LOAD : IDLE;
                LOAD:    next = STREAM;
                STREAM:  next = (cnt == AW'(K_DIM - 2)) ? WAIT1 : STREAM;
                WAIT1:   next = timeout ? IDLE : PU_DONE ? CAP0 : WAIT1;
                CAP0:    next = CAP1;
                CAP1:    next = CLR;
                CLR:     next = START2;
                START2:  next = STREAM2;
                STREAM2: next = timeout ? IDLE : !PU_DONE ? STREAM2 :
                                (ROW_NUM == RW'(ROWS - 1)) ? FINISH : ROW_END;
                ROW_END: next = GAP;
                GAP:     next = LOAD;
                FINISH:  next = IDLE;
                default: next = IDLE;
            endcase
        PU_START           = state == LOAD || state == START2;
        INPUT_BRAM_RD_EN   = state == LOAD || state == STREAM || state == WAIT1;
        PU_SEL             = (state == CAP0 || state == CAP1 || state == CLR || state == START2 ||
                              state == STREAM2) ? '1 : '0;
        PU_ACC_NUM         = INPUT_BRAM_RD_EN ? AW'(K_DIM - 1) :
                             (state == CLR || state == START2 || state == STREAM2) ? AW'(K2_DIM - 1) : '0;
        DATA_IN_EN         = state == CAP0 || state == CAP1;
        PU_PREVENT_ADR_CLR = state == CAP1 || state == CLR || state == START2;
        PU_ACC_CLR         = state == CLR || state == ROW_END || state == FINISH;
        SHIFT_EN           = state == STREAM2;
        DONE_ROW           = state == ROW_END || state == FINISH;
        DONE               = state == FINISH;
        BUSY               = state != IDLE;
    end
endmodule

// File: tb/tb_cmm_chain_controller.sv
// tb_cmm_chain_controller: directed bench for a K_DIM=4, K2_DIM=3, ROWS=3 controller.
module tb_cmm_chain_controller;
    logic        CLK = 1'b0;
    logic        RST, START, ABORT, PU_DONE;
    logic [10:0] BASE_ADDR;
    logic        PU_PREVENT_ADR_CLR, PU_ACC_CLR, PU_START, INPUT_BRAM_RD_EN;
    logic        SHIFT_EN, DATA_IN_EN, BUSY, DONE, DONE_ROW, ERROR;
    logic [1:0]  PU_ACC_NUM, PU_SEL, ROW_NUM;
    logic [10:0] INPUT_BRAM_ADDR;
    logic [10:0] obs;
    int          n_checks = 0;
    int          n_fail   = 0;

    // {prevent, acc_clr, start, sel[1:0], rd_en, shift, data_in, busy, done, done_row}
    localparam logic [10:0] P_IDLE  = 11'b0_0_0_00_0_0_0_0_0_0;
    localparam logic [10:0] P_LOAD  = 11'b0_0_1_00_1_0_0_1_0_0;
    localparam logic [10:0] P_RD    = 11'b0_0_0_00_1_0_0_1_0_0;
    localparam logic [10:0] P_CAP0  = 11'b0_0_0_11_0_0_1_1_0_0;
    localparam logic [10:0] P_CAP1  = 11'b1_0_0_11_0_0_1_1_0_0;
    localparam logic [10:0] P_CLR   = 11'b1_1_0_11_0_0_0_1_0_0;
    localparam logic [10:0] P_ST2   = 11'b1_0_1_11_0_0_0_1_0_0;
    localparam logic [10:0] P_S2    = 11'b0_0_0_11_0_1_0_1_0_0;
    localparam logic [10:0] P_REND  = 11'b0_1_0_00_0_0_0_1_0_1;
    localparam logic [10:0] P_GAP   = 11'b0_0_0_00_0_0_0_1_0_0;
    localparam logic [10:0] P_FIN   = 11'b0_1_0_00_0_0_0_1_1_1;

    cmm_chain_controller #(
        .K_DIM(4), .K2_DIM(3), .ROWS(3), .NUM_PU(2), .ADDR_W(11), .TIMEOUT_CYC(16)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .BASE_ADDR(BASE_ADDR),
        .PU_DONE(PU_DONE), .PU_PREVENT_ADR_CLR(PU_PREVENT_ADR_CLR), .PU_ACC_CLR(PU_ACC_CLR),
        .PU_START(PU_START), .PU_ACC_NUM(PU_ACC_NUM), .PU_SEL(PU_SEL),
        .INPUT_BRAM_ADDR(INPUT_BRAM_ADDR), .INPUT_BRAM_RD_EN(INPUT_BRAM_RD_EN),
        .SHIFT_EN(SHIFT_EN), .DATA_IN_EN(DATA_IN_EN), .BUSY(BUSY), .DONE(DONE),
        .DONE_ROW(DONE_ROW), .ROW_NUM(ROW_NUM), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    assign obs = {PU_PREVENT_ADR_CLR, PU_ACC_CLR, PU_START, PU_SEL, INPUT_BRAM_RD_EN,
                  SHIFT_EN, DATA_IN_EN, BUSY, DONE, DONE_ROW};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [10:0] v, input int acc,
                           input logic [10:0] a, input int r);
        check({tag, "_out"}, obs, v);
        check({tag, "_acc"}, PU_ACC_NUM, acc);
        check({tag, "_addr"}, INPUT_BRAM_ADDR, a);
        check({tag, "_row"}, ROW_NUM, r);
    endtask

    // entered with the DUT in LOAD; leaves it in LOAD of the next row, or IDLE
    task automatic do_row(input logic [10:0] a0, input int r, input bit last,
                          input bit noise, input bit abrt);
        PU_DONE = noise;
        chk_out("load", P_LOAD, 3, a0, r);
        tick;
        for (int i = 0; i < 3; i++) begin
            chk_out("stream", P_RD, 3, a0 + 11'(i), r);
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            PU_DONE = (i == 2);
            ABORT   = abrt && i == 2;
            chk_out("wait1", P_RD, 3, a0 + 11'd3, r);
            tick;
        end
        PU_DONE = noise;
        ABORT   = 1'b0;
        if (abrt) begin
            chk_out("abort", P_IDLE, 0, a0 + 11'd3, r);
            tick;
            chk_out("abort_hold", P_IDLE, 0, a0 + 11'd3, r);
            return;
        end
        chk_out("cap0", P_CAP0, 0, a0 + 11'd3, r);
        tick;
        chk_out("cap1", P_CAP1, 0, a0 + 11'd3, r);
        tick;
        chk_out("clr", P_CLR, 2, a0 + 11'd3, r);
        tick;
        chk_out("start2", P_ST2, 2, a0 + 11'd3, r);
        tick;
        for (int i = 0; i < 5; i++) begin
            PU_DONE = (i == 4);
            START   = 1'b1;
            chk_out("stream2", P_S2, 2, a0 + 11'd3, r);
            tick;
        end
        PU_DONE = 1'b0;
        START   = 1'b0;
        if (last) begin
            chk_out("finish", P_FIN, 0, a0 + 11'd3, r);
            tick;
            chk_out("idle", P_IDLE, 0, a0 + 11'd3, r);
        end else begin
            chk_out("row_end", P_REND, 0, a0 + 11'd3, r);
            tick;
            chk_out("gap", P_GAP, 0, a0 + 11'd4, r + 1);
            tick;
        end
    endtask

    task automatic launch(input logic [10:0] base);
        BASE_ADDR = base;
        START     = 1'b1;
        tick;
        START     = 1'b0;
        BASE_ADDR = 11'h555;
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; PU_DONE = 1'b0; BASE_ADDR = '0;
        repeat (3) tick;
        chk_out("reset", P_IDLE, 0, 0, 0);
        check("reset_err", ERROR, 0);
        RST = 1'b0;
        START = 1'b1; ABORT = 1'b1; BASE_ADDR = 11'h123;
        tick;
        chk_out("start_abort_idle", P_IDLE, 0, 0, 0);
        START = 1'b0; ABORT = 1'b0;

        launch(11'h010);
        do_row(11'h010, 0, 0, 0, 0);
        do_row(11'h014, 1, 0, 1, 0);
        do_row(11'h018, 2, 1, 0, 0);

        launch(11'h7FE);
        do_row(11'h7FE, 0, 0, 0, 0);
        do_row(11'h002, 1, 0, 0, 0);
        do_row(11'h006, 2, 1, 1, 0);

        launch(11'h100);
        do_row(11'h100, 0, 0, 0, 0);
        do_row(11'h104, 1, 0, 0, 1);
        launch(11'h200);
        do_row(11'h200, 0, 0, 0, 1);

        launch(11'h040);
        chk_out("to_load", P_LOAD, 3, 11'h040, 0);
        repeat (4) tick;
        chk_out("to_wait1", P_RD, 3, 11'h043, 0);
        repeat (15) tick;
        check("to_pre_err", ERROR, 0);
        check("to_pre_busy", BUSY, 1);
`ifdef CMM_TIMEOUT_EN
        tick;
        check("to_err", ERROR, 1);
        chk_out("to_idle", P_IDLE, 0, 11'h043, 0);
        tick;
        check("to_err_sticky", ERROR, 1);
        launch(11'h080);
        check("to_err_clr", ERROR, 0);
        chk_out("to_restart", P_LOAD, 3, 11'h080, 0);
        ABORT = 1'b1;
        tick;
        ABORT = 1'b0;
        chk_out("to_abort", P_IDLE, 0, 11'h080, 0);
`else
        repeat (10) tick;
        check("no_to_err", ERROR, 0);
        chk_out("no_to_wait", P_RD, 3, 11'h043, 0);
        ABORT = 1'b1;
        tick;
        ABORT = 1'b0;
        chk_out("no_to_abort", P_IDLE, 0, 11'h043, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
